// File: rtl/prga_gen.sv
// RC4 PRGA: reads length header + ciphertext from CT RAM, writes header + plaintext to PT RAM.
// Multi-cycle (10 cycles per data byte, 7 per dropped byte); en is accepted only while rdy=1, never queued.
module prga_gen #(
  parameter int LEN_BYTES   = 1,
  parameter int ADDR_W      = 8,
  parameter int DROP_N      = 0,
  parameter int CHECK_ASCII = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic              rdy,
  output logic              ok,
  output logic [7:0]        s_addr,
  input  logic [7:0]        s_dout,
  output logic [7:0]        s_din,
  output logic              s_wren,
  output logic [ADDR_W-1:0] ct_addr,
  input  logic [7:0]        ct_dout,
  output logic [7:0]        ct_din,
  output logic              ct_wren,
  output logic [ADDR_W-1:0] pt_addr,
  output logic [7:0]        pt_din,
  output logic              pt_wren
);

  localparam int HW = 8 * LEN_BYTES;
  localparam int LW = ADDR_W + 1;
  localparam int DW = 10;
  localparam logic [LW-1:0] MAX_L = LW'((1 << ADDR_W) - LEN_BYTES);

  typedef enum logic [3:0] {
    IDLE, H_RD, H_GET, H_LEN,
    K_INC, K_RDI, K_GETI, K_RDJ, K_GETJ, K_WRJ, K_WRI,
    K_RDP, K_GETP, K_PWR, DONE
  } state_t;

  state_t state, state_nx;

  logic [7:0]    i, j, si, sj, pt_byte;
  logic [LW-1:0] k, len, len_cl, hdr_ext, k_nx;
  logic [DW-1:0] drop_cnt;
  logic [HW-1:0] hdr_acc;
  logic          hb, hb_last, bad_char, abort;

  assign hdr_ext  = LW'(hdr_acc);
  assign len_cl   = (hdr_ext > MAX_L) ? MAX_L : hdr_ext;
  assign hb_last  = (LEN_BYTES == 1) || hb;
  assign k_nx     = k + LW'(1);
  assign bad_char = (pt_byte < 8'h20) || (pt_byte > 8'h7E);
  assign abort    = (CHECK_ASCII != 0) && bad_char;
  assign ct_din   = 8'h00;
  assign ct_wren  = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   if (en) state_nx = H_RD;
      H_RD:   state_nx = H_GET;
      H_GET:  state_nx = hb_last ? H_LEN : H_RD;
      H_LEN: begin
        if (drop_cnt != '0)        state_nx = K_INC;
        else if (len_cl == '0)     state_nx = DONE;
        else                       state_nx = K_INC;
      end
      K_INC:  state_nx = K_RDI;
      K_RDI:  state_nx = K_GETI;
      K_GETI: state_nx = K_RDJ;
      K_RDJ:  state_nx = K_GETJ;
      K_GETJ: state_nx = K_WRJ;
      K_WRJ:  state_nx = K_WRI;
      // Last dropped step falls through to the data phase, or straight to DONE for L=0.
      K_WRI: begin
        if (drop_cnt == '0)          state_nx = K_RDP;
        else if (drop_cnt > DW'(1))  state_nx = K_INC;
        else if (len == '0)          state_nx = DONE;
        else                         state_nx = K_INC;
      end
      K_RDP:  state_nx = K_GETP;
      K_GETP: state_nx = K_PWR;
      K_PWR:  state_nx = (abort || k_nx == len) ? DONE : K_INC;
      DONE:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    rdy     = 1'b0;
    s_addr  = 8'h00;
    s_din   = 8'h00;
    s_wren  = 1'b0;
    ct_addr = '0;
    pt_addr = '0;
    pt_din  = 8'h00;
    pt_wren = 1'b0;
    case (state)
      IDLE:  rdy = 1'b1;
      H_RD:  ct_addr = ADDR_W'(hb);
      H_GET: begin
        ct_addr = ADDR_W'(hb);
        pt_addr = ADDR_W'(hb);
        pt_din  = ct_dout;
        pt_wren = 1'b1;
      end
      K_RDI: s_addr = i;
      K_RDJ: s_addr = j;
      K_WRJ: begin
        s_addr = j;
        s_din  = si;
        s_wren = 1'b1;
      end
      K_WRI: begin
        s_addr = i;
        s_din  = sj;
        s_wren = 1'b1;
      end
      K_RDP: begin
        s_addr  = si + sj;
        ct_addr = ADDR_W'(LEN_BYTES) + k[ADDR_W-1:0];
      end
      K_PWR: begin
        pt_addr = ADDR_W'(LEN_BYTES) + k[ADDR_W-1:0];
        pt_din  = pt_byte;
        pt_wren = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i        <= 8'h00;
      j        <= 8'h00;
      si       <= 8'h00;
      sj       <= 8'h00;
      pt_byte  <= 8'h00;
      k        <= '0;
      len      <= '0;
      drop_cnt <= '0;
      hdr_acc  <= '0;
      hb       <= 1'b0;
      ok       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (en) begin
          i        <= 8'h00;
          j        <= 8'h00;
          k        <= '0;
          hdr_acc  <= '0;
          hb       <= 1'b0;
          drop_cnt <= DW'(DROP_N);
          ok       <= 1'b1;
        end
        H_GET: begin
          if (!hb) hdr_acc[7:0]      <= ct_dout;
          else     hdr_acc[HW-1 -: 8] <= ct_dout;
          hb <= ~hb;
        end
        H_LEN:  len <= len_cl;
        K_INC:  i <= i + 8'h01;
        K_GETI: begin
          si <= s_dout;
          j  <= j + s_dout;
        end
        K_GETJ: sj <= s_dout;
        K_WRI:  if (drop_cnt != '0) drop_cnt <= drop_cnt - DW'(1);
        K_GETP: pt_byte <= s_dout ^ ct_dout;
        K_PWR: begin
          k <= k_nx;
          if (abort) ok <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prga_gen.sv
// Directed bench: four prga_gen configurations sharing one clock/reset, each with its own RAM models.
module tb_prga_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        en [4];
  logic        rdy [4];
  logic        ok [4];
  logic [7:0]  s_addr_a [4];
  logic [7:0]  s_din_a [4];
  logic [7:0]  s_dout_a [4];
  logic        s_wren_a [4];
  logic [15:0] ct_addr_a [4];
  logic [7:0]  ct_dout_a [4];
  logic [7:0]  ct_din_a [4];
  logic        ct_wren_a [4];
  logic [15:0] pt_addr_a [4];
  logic [7:0]  pt_din_a [4];
  logic        pt_wren_a [4];

  logic        do_init [4];
  logic [7:0]  ct_img [4][16];
  logic [7:0]  s_mem [4][256];
  logic [7:0]  pt_mem [4][16];
  int          pt_cnt [4];
  int          s_cnt [4];
  bit          ct_bad [4];

  int n_cmp = 0;
  int n_bad = 0;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int AW = (g == 3) ? 16 : 8;
    logic [AW-1:0] ct_addr, pt_addr;
    prga_gen #(
      .LEN_BYTES  ((g == 3) ? 2 : 1),
      .ADDR_W     (AW),
      .DROP_N     ((g == 2) ? 1 : 0),
      .CHECK_ASCII((g == 1) ? 1 : 0)
    ) u_dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (en[g]),
      .rdy    (rdy[g]),
      .ok     (ok[g]),
      .s_addr (s_addr_a[g]),
      .s_dout (s_dout_a[g]),
      .s_din  (s_din_a[g]),
      .s_wren (s_wren_a[g]),
      .ct_addr(ct_addr),
      .ct_dout(ct_dout_a[g]),
      .ct_din (ct_din_a[g]),
      .ct_wren(ct_wren_a[g]),
      .pt_addr(pt_addr),
      .pt_din (pt_din_a[g]),
      .pt_wren(pt_wren_a[g])
    );
    assign ct_addr_a[g] = 16'(ct_addr);
    assign pt_addr_a[g] = 16'(pt_addr);
  end

  // Synchronous RAM models: read data appears the cycle after the address.
  always @(posedge clk) begin
    for (int g = 0; g < 4; g++) begin
      if (do_init[g]) begin
        for (int x = 0; x < 256; x++) s_mem[g][x] <= 8'(x);
        for (int x = 0; x < 16; x++)  pt_mem[g][x] <= 8'hEE;
      end else begin
        s_dout_a[g] <= s_mem[g][s_addr_a[g]];
        if (s_wren_a[g]) begin
          s_mem[g][s_addr_a[g]] <= s_din_a[g];
          s_cnt[g] <= s_cnt[g] + 1;
        end
        ct_dout_a[g] <= (ct_addr_a[g] < 16'd16) ? ct_img[g][ct_addr_a[g][3:0]] : 8'h00;
        if (pt_wren_a[g]) begin
          if (pt_addr_a[g] < 16'd16) pt_mem[g][pt_addr_a[g][3:0]] <= pt_din_a[g];
          pt_cnt[g] <= pt_cnt[g] + 1;
        end
        if (ct_wren_a[g] || ct_din_a[g] != 8'h00) ct_bad[g] <= 1'b1;
      end
    end
  end

  // Load CT bytes (first byte in the most significant used position), identity S, PT filled with EE.
  task automatic load(input int g, input int n, input logic [127:0] v);
    for (int m = 0; m < 16; m++) begin
      if (m < n) ct_img[g][m] = v[8*(n-1-m) +: 8];
      else       ct_img[g][m] = 8'h00;
    end
    do_init[g] = 1'b1;
    @(negedge clk);
    do_init[g] = 1'b0;
  endtask

  task automatic run_job(input int g, output bit done);
    en[g] = 1'b1;
    @(negedge clk);
    en[g] = 1'b0;
    for (int c = 0; c < 3000 && rdy[g] !== 1'b1; c++) @(negedge clk);
    done = (rdy[g] === 1'b1);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 4; g++) begin
      n_cmp += 4;
      if (rdy[g] !== 1'b1) begin n_bad++; $display("FAIL reset_rdy[%0d] got %b want 1", g, rdy[g]); end
      if (ok[g] !== 1'b0) begin n_bad++; $display("FAIL reset_ok[%0d] got %b want 0", g, ok[g]); end
      if (pt_wren_a[g] !== 1'b0) begin n_bad++; $display("FAIL reset_pt_wren[%0d] got %b want 0", g, pt_wren_a[g]); end
      if (s_wren_a[g] !== 1'b0) begin n_bad++; $display("FAIL reset_s_wren[%0d] got %b want 0", g, s_wren_a[g]); end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    logic [31:0] pv = 32'h03414243;
    logic [55:0] sv = 56'h01030504020607;
    int p0, s0;
    bit done;
    load(0, 4, 128'h03434744);
    p0 = pt_cnt[0]; s0 = s_cnt[0];
    run_job(0, done);
    n_cmp += 5;
    if (!done) begin n_bad++; $display("FAIL basic_done timeout"); end
    if (ok[0] !== 1'b1) begin n_bad++; $display("FAIL basic_ok got %b want 1", ok[0]); end
    if (pt_cnt[0] - p0 != 4) begin n_bad++; $display("FAIL basic_pt_pulses got %0d want 4", pt_cnt[0] - p0); end
    if (s_cnt[0] - s0 != 6) begin n_bad++; $display("FAIL basic_s_pulses got %0d want 6", s_cnt[0] - s0); end
    if (ct_bad[0]) begin n_bad++; $display("FAIL basic_ct_write got 1 want 0"); end
    for (int m = 0; m < 4; m++) begin
      n_cmp++;
      if (pt_mem[0][m] !== pv[8*(3-m) +: 8]) begin
        n_bad++; $display("FAIL basic_pt[%0d] got %h want %h", m, pt_mem[0][m], pv[8*(3-m) +: 8]);
      end
    end
    for (int m = 1; m < 8; m++) begin
      n_cmp++;
      if (s_mem[0][m] !== sv[8*(7-m) +: 8]) begin
        n_bad++; $display("FAIL basic_s[%0d] got %h want %h", m, s_mem[0][m], sv[8*(7-m) +: 8]);
      end
    end
  endtask

  task automatic test_ascii_abort;
    logic [31:0] pv = 32'h034100EE;
    int p0;
    bit done;
    load(1, 4, 128'h03430544);
    p0 = pt_cnt[1];
    run_job(1, done);
    n_cmp += 3;
    if (!done) begin n_bad++; $display("FAIL ascii_done timeout"); end
    if (ok[1] !== 1'b0) begin n_bad++; $display("FAIL ascii_ok got %b want 0", ok[1]); end
    if (pt_cnt[1] - p0 != 3) begin n_bad++; $display("FAIL ascii_pt_pulses got %0d want 3", pt_cnt[1] - p0); end
    for (int m = 0; m < 4; m++) begin
      n_cmp++;
      if (pt_mem[1][m] !== pv[8*(3-m) +: 8]) begin
        n_bad++; $display("FAIL ascii_pt[%0d] got %h want %h", m, pt_mem[1][m], pv[8*(3-m) +: 8]);
      end
    end
  endtask

  task automatic test_drop;
    logic [23:0] pv = 24'h024142;
    int p0, s0;
    bit done;
    load(2, 3, 128'h024445);
    p0 = pt_cnt[2]; s0 = s_cnt[2];
    run_job(2, done);
    n_cmp += 4;
    if (!done) begin n_bad++; $display("FAIL drop_done timeout"); end
    if (ok[2] !== 1'b1) begin n_bad++; $display("FAIL drop_ok got %b want 1", ok[2]); end
    if (pt_cnt[2] - p0 != 3) begin n_bad++; $display("FAIL drop_pt_pulses got %0d want 3", pt_cnt[2] - p0); end
    if (s_cnt[2] - s0 != 6) begin n_bad++; $display("FAIL drop_s_pulses got %0d want 6", s_cnt[2] - s0); end
    for (int m = 0; m < 3; m++) begin
      n_cmp++;
      if (pt_mem[2][m] !== pv[8*(2-m) +: 8]) begin
        n_bad++; $display("FAIL drop_pt[%0d] got %h want %h", m, pt_mem[2][m], pv[8*(2-m) +: 8]);
      end
    end
  endtask

  task automatic test_len2;
    logic [39:0] pv = 40'h0300414243;
    int p0;
    bit done;
    load(3, 5, 128'h0300434744);
    p0 = pt_cnt[3];
    run_job(3, done);
    n_cmp += 3;
    if (!done) begin n_bad++; $display("FAIL len2_done timeout"); end
    if (ok[3] !== 1'b1) begin n_bad++; $display("FAIL len2_ok got %b want 1", ok[3]); end
    if (pt_cnt[3] - p0 != 5) begin n_bad++; $display("FAIL len2_pt_pulses got %0d want 5", pt_cnt[3] - p0); end
    for (int m = 0; m < 5; m++) begin
      n_cmp++;
      if (pt_mem[3][m] !== pv[8*(4-m) +: 8]) begin
        n_bad++; $display("FAIL len2_pt[%0d] got %h want %h", m, pt_mem[3][m], pv[8*(4-m) +: 8]);
      end
    end
  endtask

  task automatic test_zero_len;
    int p0, s0;
    bit done;
    load(0, 1, 128'h00);
    p0 = pt_cnt[0]; s0 = s_cnt[0];
    run_job(0, done);
    n_cmp += 6;
    if (!done) begin n_bad++; $display("FAIL zero_done timeout"); end
    if (ok[0] !== 1'b1) begin n_bad++; $display("FAIL zero_ok got %b want 1", ok[0]); end
    if (s_cnt[0] - s0 != 0) begin n_bad++; $display("FAIL zero_s_pulses got %0d want 0", s_cnt[0] - s0); end
    if (pt_cnt[0] - p0 != 1) begin n_bad++; $display("FAIL zero_pt_pulses got %0d want 1", pt_cnt[0] - p0); end
    if (pt_mem[0][0] !== 8'h00) begin n_bad++; $display("FAIL zero_pt[0] got %h want 00", pt_mem[0][0]); end
    if (pt_mem[0][1] !== 8'hEE) begin n_bad++; $display("FAIL zero_pt[1] got %h want EE", pt_mem[0][1]); end
  endtask

  task automatic test_en_ignored;
    logic [31:0] pv = 32'h03414243;
    int p0;
    bit done;
    load(0, 4, 128'h03434744);
    p0 = pt_cnt[0];
    en[0] = 1'b1;
    @(negedge clk);
    en[0] = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (rdy[0] !== 1'b0) begin n_bad++; $display("FAIL busy_rdy got %b want 0", rdy[0]); end
    en[0] = 1'b1;
    @(negedge clk);
    en[0] = 1'b0;
    for (int c = 0; c < 3000 && rdy[0] !== 1'b1; c++) @(negedge clk);
    done = (rdy[0] === 1'b1);
    repeat (20) @(negedge clk);
    n_cmp += 3;
    if (!done) begin n_bad++; $display("FAIL busy_done timeout"); end
    if (rdy[0] !== 1'b1) begin n_bad++; $display("FAIL busy_requeued rdy got %b want 1", rdy[0]); end
    if (pt_cnt[0] - p0 != 4) begin n_bad++; $display("FAIL busy_pt_pulses got %0d want 4", pt_cnt[0] - p0); end
    for (int m = 0; m < 4; m++) begin
      n_cmp++;
      if (pt_mem[0][m] !== pv[8*(3-m) +: 8]) begin
        n_bad++; $display("FAIL busy_pt[%0d] got %h want %h", m, pt_mem[0][m], pv[8*(3-m) +: 8]);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] pv = 32'h03414243;
    int p0;
    bit found, done;
    load(0, 12, 128'h0B41_4141_4141_4141_4141_4141);
    p0 = pt_cnt[0];
    en[0] = 1'b1;
    @(negedge clk);
    en[0] = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 3000 && !found; c++) begin
      if (pt_wren_a[0] === 1'b1 && pt_cnt[0] - p0 >= 3) found = 1'b1;
      else @(negedge clk);
    end
    n_cmp++;
    if (!found) begin n_bad++; $display("FAIL mid_reach_data timeout"); end
    rst_n = 1'b0;
    #1;
    n_cmp += 3;
    if (pt_wren_a[0] !== 1'b0) begin n_bad++; $display("FAIL mid_pt_wren got %b want 0", pt_wren_a[0]); end
    if (rdy[0] !== 1'b1) begin n_bad++; $display("FAIL mid_rdy got %b want 1", rdy[0]); end
    if (ok[0] !== 1'b0) begin n_bad++; $display("FAIL mid_ok got %b want 0", ok[0]); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    load(0, 4, 128'h03434744);
    run_job(0, done);
    n_cmp += 2;
    if (!done) begin n_bad++; $display("FAIL mid_rerun_done timeout"); end
    if (ok[0] !== 1'b1) begin n_bad++; $display("FAIL mid_rerun_ok got %b want 1", ok[0]); end
    for (int m = 0; m < 4; m++) begin
      n_cmp++;
      if (pt_mem[0][m] !== pv[8*(3-m) +: 8]) begin
        n_bad++; $display("FAIL mid_rerun_pt[%0d] got %h want %h", m, pt_mem[0][m], pv[8*(3-m) +: 8]);
      end
    end
  endtask

  initial begin
    for (int g = 0; g < 4; g++) begin
      en[g] = 1'b0;
      do_init[g] = 1'b0;
      for (int m = 0; m < 16; m++) ct_img[g][m] = 8'h00;
    end
    test_reset;
    test_basic;
    test_ascii_abort;
    test_drop;
    test_len2;
    test_zero_len;
    test_en_ignored;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/prga_gen.md
Name: prga_gen

Overview:
Parametrised RC4 keystream/decrypt engine, successor to the single-byte-length PRGA in the cipher lab. Operates on an S RAM already initialised by the KSA. Reads a length header and ciphertext from CT RAM, then writes header and plaintext to PT RAM. Adds three features for the key-cracking datapath: configurable length-header width, RC4-drop[N] keystream discard, and optional early abort on non-printable plaintext.

Parameters:
LEN_BYTES, 1, header width in bytes (1 or 2); length L is little-endian over ct[0..LEN_BYTES-1].
ADDR_W, 8, CT/PT RAM address width; must be ≥ 8*LEN_BYTES.
DROP_N, 0, keystream bytes generated and discarded before the first data byte (0..1023).
CHECK_ASCII, 0, 1 = abort on the first plaintext byte outside 0x20..0x7E.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
en  in  1  start request; sampled only while rdy=1
rdy  out  1  high only in IDLE
ok  out  1  result of last job; valid while rdy=1
s_addr  out  8  S RAM address
s_dout  in  8  S RAM read data
s_din  out  8  S RAM write data
s_wren  out  1  S RAM write enable
ct_addr  out  ADDR_W  CT RAM address
ct_dout  in  8  CT RAM read data
ct_din  out  8  constant 0
ct_wren  out  1  constant 0
pt_addr  out  ADDR_W  PT RAM address
pt_din  out  8  PT RAM write data
pt_wren  out  1  PT RAM write enable

Behaviour:
- All RAMs are synchronous: dout reflects the address registered at the previous edge. One wait state per read.
- Reset values: all outputs 0 except rdy=1. Internal i, j, k, L, drop counter all 0. FSM in IDLE.
- rst_n asserted mid-job: immediate return to IDLE; pt_wren and s_wren drop to 0 asynchronously. Partial RAM contents are undefined.
- IDLE: when en=1, clear i=j=k=0 and set ok=1, then go to HDR. en while rdy=0 is ignored (no queueing).
- HDR: read ct[0..LEN_BYTES-1], assemble L, copy each byte to the same pt address.
- Clamp L to 2^ADDR_W − LEN_BYTES; the copied header is the unclamped original.
- Keystream step (8-bit wrap on all S arithmetic):
  - i=i+1
  - si=S[i]
  - j=j+si
  - sj=S[j]
  - write S[j]=si, then S[i]=sj (two separate cycles)
  - pad=S[si+sj]
  - When i==j, both writes store the same value; the result must equal a correct swap.
- DROP: run DROP_N keystream steps with no pad read and no PT/CT access, then enter DATA. With DROP_N=0, DATA is entered directly.
- DATA, per k in 0..L−1:
  - keystream step
  - read ct[LEN_BYTES+k]
  - write pt[LEN_BYTES+k]=pad^ct, with pt_wren high for exactly one cycle
  - k=k+1
- k is ADDR_W+1 bits wide and has no wrap.
- L=0: header written, no keystream steps beyond DROP, then DONE.
- CHECK_ASCII=1: the offending byte is still written. ok then clears to 0 and the FSM goes to DONE, skipping the remaining bytes.
- DONE: deassert all wrens for one cycle, then IDLE. ok holds until the next accepted en.
- Cycle count per byte is not part of the interface. Bound: ≤16 cycles per keystream step plus ≤4 per header byte.

Test Plan:
- Identity S (S[x]=x), DROP_N=0, LEN_BYTES=1, CT=[03,43,47,44] -> keystream 02,05,07; PT=[03,41,42,43]; ok=1; S[1..7]=1,3,5,4,2,6,7; exactly 4 pt_wren pulses.
- Same, CHECK_ASCII=1, CT=[03,43,05,44] -> PT[2]=00 written, pt[3] never written, 3 pt_wren pulses, ok=0.
- Identity S, DROP_N=1, CT=[02,44,45] -> pad 02 discarded; PT=[02,41,42]; ok=1.
- LEN_BYTES=2, ADDR_W=16, identity S, CT=[03,00,43,47,44] -> PT=[03,00,41,42,43].
- CT=[00] -> PT=[00], no s_wren pulses, rdy returns high, ok=1.
- Pulse en during a job (ignored: PT unchanged). Assert rst_n low mid-DATA -> rdy=1 and pt_wren=0 immediately. A fresh job on a reinitialised S then produces the correct PT.
